// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_arb_pkg                                                  |
// | Description : Shared types and constants for the two-requester block RAM   |
// |               arbiter: FSM state encoding and requester index constants.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    // Arbiter FSM: one outstanding transaction at most.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } arb_state_t;

    // Requester indices into the per-requester port vectors.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LSU   = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_grant2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_grant2                                                    |
// | Description : Two-way round-robin grant, purely combinational.             |
// |               A lone valid requester always wins; on a tie the requester   |
// |               that did not win last time is chosen.                        |
// | Ports       : valid[1:0] - request valid per requester                     |
// |               last       - index of the previously granted requester       |
// |               grant      - index of the granted requester                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_grant2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = ~last;
        // Exactly one requester valid: it wins regardless of history.
        if (valid[REQ_FETCH] ^ valid[REQ_LSU]) begin
            grant = valid[REQ_LSU];
        end
    end

endmodule : rr_grant2
`default_nettype wire

// File: rtl/block_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : block_ram_arbiter                                            |
// | Description : Arbitrates a fetch and a load/store requester onto a single  |
// |               block RAM port with one transaction in flight. Responses are |
// |               routed back to the owner of the outstanding request; a new   |
// |               request may issue in the same cycle a response returns.      |
// |               A response timeout or a response with nothing outstanding    |
// |               sets the sticky err flag.                                    |
// | Ports       : clock, reset (async, active-low)                             |
// |               io_req_*  - per-requester request channel (slice i = req i)  |
// |               io_rsp_*  - per-requester response pulse, shared data        |
// |               mem_req_* - block RAM request channel                        |
// |               mem_rsp_* - block RAM response                               |
// |               err       - sticky error flag                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module block_ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      io_req_valid,
    output logic [1:0]      io_req_ready,
    input  logic [2*AW-1:0] io_req_addr,
    input  logic [2*DW-1:0] io_req_data,
    input  logic [1:0]      io_req_isWrite,
    output logic [1:0]      io_rsp_valid,
    output logic [DW-1:0]   io_rsp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic [DW-1:0]   mem_req_data,
    output logic            mem_req_isWrite,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rsp_data,
    output logic            err
);

    localparam int                   c_timer_w      = $clog2(TIMEOUT + 1);
    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(TIMEOUT - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic                 r_owner;
    logic                 r_last_grant;
    logic [c_timer_w-1:0] r_timer;
    logic                 r_err;

    logic w_run;
    logic w_grant;
    logic w_issue_ok;
    logic w_fire;
    logic w_rsp_hit;
    logic w_timeout;
    logic w_spurious;

    // Outputs are forced low combinationally while reset is held, so the
    // async reset blocks inputs from leaking through the request muxes.
    assign w_run = reset;

    rr_grant2 u_rr_grant2 (
        .valid (io_req_valid),
        .last  (r_last_grant),
        .grant (w_grant)
    );

    // A new request may issue when idle, or when the outstanding one
    // completes this very cycle (back-to-back).
    assign w_issue_ok = w_run && ((r_state == IDLE) ||
                                  ((r_state == WAIT_RSP) && mem_rsp_valid));
    assign w_fire     = mem_req_valid && mem_req_ready;
    assign w_rsp_hit  = w_run && (r_state == WAIT_RSP) && mem_rsp_valid;
    assign w_timeout  = (r_state == WAIT_RSP) && !mem_rsp_valid &&
                        (r_timer == c_timeout_last);
    assign w_spurious = (r_state == IDLE) && mem_rsp_valid;

    assign mem_req_valid   = w_issue_ok && (|io_req_valid);
    assign mem_req_addr    = !w_run ? '0 :
                             (w_grant ? io_req_addr[2*AW-1:AW] : io_req_addr[AW-1:0]);
    assign mem_req_data    = !w_run ? '0 :
                             (w_grant ? io_req_data[2*DW-1:DW] : io_req_data[DW-1:0]);
    assign mem_req_isWrite = w_run && io_req_isWrite[w_grant];

    assign io_req_ready[REQ_FETCH] = w_issue_ok && (w_grant == REQ_FETCH) && mem_req_ready;
    assign io_req_ready[REQ_LSU]   = w_issue_ok && (w_grant == REQ_LSU)   && mem_req_ready;

    // The response belongs to the registered owner, never to a request
    // firing in the same cycle.
    assign io_rsp_valid[REQ_FETCH] = w_rsp_hit && (r_owner == REQ_FETCH);
    assign io_rsp_valid[REQ_LSU]   = w_rsp_hit && (r_owner == REQ_LSU);
    assign io_rsp_data             = w_run ? mem_rsp_data : '0;

    assign err = r_err;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire) w_state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    w_state_next = w_fire ? WAIT_RSP : IDLE;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= REQ_FETCH;
            r_last_grant <= REQ_LSU;    // fetch wins the first tie
            r_timer      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_fire) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_timer      <= '0;
            end else if ((r_state == WAIT_RSP) && !mem_rsp_valid && !w_timeout) begin
                r_timer <= r_timer + c_timer_w'(1);
            end
            if (w_timeout || w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule : block_ram_arbiter
`default_nettype wire

// File: tb/tb_block_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_block_ram_arbiter                                         |
// | Description : Directed self-checking bench for block_ram_arbiter.          |
// |               Inputs change 1 time unit after the rising edge; outputs are |
// |               checked 1 time unit later, well before the next edge.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_block_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      io_req_valid   = '0;
    logic [1:0]      io_req_ready;
    logic [2*AW-1:0] io_req_addr    = '0;
    logic [2*DW-1:0] io_req_data    = '0;
    logic [1:0]      io_req_isWrite = '0;
    logic [1:0]      io_rsp_valid;
    logic [DW-1:0]   io_rsp_data;
    logic            mem_req_valid;
    logic            mem_req_ready  = 1'b0;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data;
    logic            mem_req_isWrite;
    logic            mem_rsp_valid  = 1'b0;
    logic [DW-1:0]   mem_rsp_data   = '0;
    logic            err;

    int n_cmp = 0;
    int n_err = 0;

    block_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_req_valid    (io_req_valid),
        .io_req_ready    (io_req_ready),
        .io_req_addr     (io_req_addr),
        .io_req_data     (io_req_data),
        .io_req_isWrite  (io_req_isWrite),
        .io_rsp_valid    (io_rsp_valid),
        .io_rsp_data     (io_rsp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_isWrite (mem_req_isWrite),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .err             (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle after changing inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset: outputs held low despite active inputs
        io_req_valid  = 2'b01;
        io_req_addr   = {32'h0000_0200, 32'h0000_0100};
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_2222;
        step();
        settle();
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_io_req_ready",  64'(io_req_ready),  64'd0);
        chk("rst_io_rsp_valid",  64'(io_rsp_valid),  64'd0);
        chk("rst_mem_req_addr",  64'(mem_req_addr),  64'd0);
        chk("rst_err",           64'(err),           64'd0);
        mem_rsp_valid = 1'b0;
        io_req_valid  = 2'b00;
        step();
        reset = 1'b1;
        step();

        // ---------------- round robin, both valid, 4 back-to-back txns
        io_req_valid = 2'b11;
        settle();
        chk("rr0_ready", 64'(io_req_ready), 64'h1);
        chk("rr0_addr",  64'(mem_req_addr), 64'h100);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_00A0;
        settle();
        chk("rr1_rsp_valid", 64'(io_rsp_valid), 64'h1);
        chk("rr1_rsp_data",  64'(io_rsp_data),  64'hA0);
        chk("rr1_ready",     64'(io_req_ready), 64'h2);
        chk("rr1_addr",      64'(mem_req_addr), 64'h200);
        step();
        mem_rsp_data = 32'h0000_00A1;
        settle();
        chk("rr2_rsp_valid", 64'(io_rsp_valid), 64'h2);
        chk("rr2_ready",     64'(io_req_ready), 64'h1);
        step();
        mem_rsp_data = 32'h0000_00A2;
        settle();
        chk("rr3_rsp_valid", 64'(io_rsp_valid), 64'h1);
        chk("rr3_ready",     64'(io_req_ready), 64'h2);
        chk("rr3_addr",      64'(mem_req_addr), 64'h200);
        step();
        io_req_valid = 2'b00;
        mem_rsp_data = 32'h0000_00A3;
        settle();
        chk("rr4_rsp_valid",     64'(io_rsp_valid),  64'h2);
        chk("rr4_mem_req_valid", 64'(mem_req_valid), 64'h0);
        step();
        mem_rsp_valid = 1'b0;

        // ---------------- single fetch read, 1-cycle latency
        io_req_valid   = 2'b01;
        io_req_addr    = {32'h0, 32'h0000_0010};
        io_req_isWrite = 2'b00;
        settle();
        chk("rd_mem_req_valid", 64'(mem_req_valid),   64'h1);
        chk("rd_addr",          64'(mem_req_addr),    64'h10);
        chk("rd_isWrite",       64'(mem_req_isWrite), 64'h0);
        chk("rd_ready",         64'(io_req_ready),    64'h1);
        chk("rd_no_rsp_fire",   64'(io_rsp_valid),    64'h0);
        step();
        io_req_valid  = 2'b00;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        settle();
        chk("rd_rsp_valid", 64'(io_rsp_valid), 64'h1);
        chk("rd_rsp_data",  64'(io_rsp_data),  64'hDEAD_BEEF);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("rd_rsp_clear", 64'(io_rsp_valid), 64'h0);
        chk("rd_err",       64'(err),          64'h0);

        // ---------------- LSU write, then fetch read in the response cycle
        io_req_valid   = 2'b10;
        io_req_addr    = {32'h0000_0020, 32'h0};
        io_req_data    = {32'h0000_1234, 32'h0};
        io_req_isWrite = 2'b10;
        settle();
        chk("wr_ready",   64'(io_req_ready),    64'h2);
        chk("wr_isWrite", 64'(mem_req_isWrite), 64'h1);
        chk("wr_data",    64'(mem_req_data),    64'h1234);
        chk("wr_addr",    64'(mem_req_addr),    64'h20);
        step();
        io_req_valid   = 2'b01;
        io_req_addr    = {32'h0, 32'h0000_0020};
        io_req_isWrite = 2'b00;
        mem_rsp_valid  = 1'b1;
        mem_rsp_data   = 32'h0;
        settle();
        chk("b2b_wr_rsp",  64'(io_rsp_valid),    64'h2);
        chk("b2b_ready",   64'(io_req_ready),    64'h1);
        chk("b2b_isWrite", 64'(mem_req_isWrite), 64'h0);
        chk("b2b_addr",    64'(mem_req_addr),    64'h20);
        step();
        io_req_valid = 2'b00;
        mem_rsp_data = 32'h0000_1234;
        settle();
        chk("b2b_rd_rsp",  64'(io_rsp_valid), 64'h1);
        chk("b2b_rd_data", 64'(io_rsp_data),  64'h1234);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("b2b_err", 64'(err), 64'h0);

        // ---------------- memory backpressure for 3 cycles
        mem_req_ready  = 1'b0;
        io_req_valid   = 2'b01;
        io_req_addr    = {32'h0, 32'h0000_0044};
        io_req_data    = {32'h0, 32'h0000_0055};
        io_req_isWrite = 2'b01;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ready", 64'(io_req_ready),  64'h0);
            chk("bp_valid", 64'(mem_req_valid), 64'h1);
            chk("bp_addr",  64'(mem_req_addr),  64'h44);
            chk("bp_data",  64'(mem_req_data),  64'h55);
            step();
        end
        mem_req_ready = 1'b1;
        settle();
        chk("bp_fire_ready", 64'(io_req_ready), 64'h1);
        step();
        io_req_valid   = 2'b00;
        io_req_isWrite = 2'b00;
        mem_rsp_valid  = 1'b1;
        mem_rsp_data   = 32'h0;
        settle();
        chk("bp_rsp", 64'(io_rsp_valid), 64'h1);
        step();
        mem_rsp_valid = 1'b0;

        // ---------------- timeout with TIMEOUT=8
        io_req_valid = 2'b10;
        io_req_addr  = {32'h0000_0080, 32'h0000_0084};
        settle();
        chk("to_ready", 64'(io_req_ready), 64'h2);
        step();
        io_req_valid = 2'b00;
        for (int i = 0; i < 7; i++) begin
            settle();
            chk("to_err_pending", 64'(err), 64'h0);
            step();
        end
        // Eighth WAIT_RSP cycle: still busy, must not issue.
        io_req_valid = 2'b01;
        settle();
        chk("to_last_err",       64'(err),           64'h0);
        chk("to_last_req_valid", 64'(mem_req_valid), 64'h0);
        chk("to_last_ready",     64'(io_req_ready),  64'h0);
        step();
        settle();
        chk("to_err_set",     64'(err),           64'h1);
        chk("to_idle_issue",  64'(mem_req_valid), 64'h1);
        chk("to_idle_ready",  64'(io_req_ready),  64'h1);
        chk("to_idle_rspv",   64'(io_rsp_valid),  64'h0);
        step();
        io_req_valid  = 2'b00;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0077;
        settle();
        chk("to_next_rsp",  64'(io_rsp_valid), 64'h1);
        chk("to_next_data", 64'(io_rsp_data),  64'h77);
        step();
        mem_rsp_valid = 1'b0;

        // ---------------- reset while waiting, late response is spurious
        io_req_valid = 2'b01;
        io_req_addr  = {32'h0, 32'h0000_0090};
        settle();
        chk("rw_ready", 64'(io_req_ready), 64'h1);
        step();
        io_req_valid = 2'b00;
        reset        = 1'b0;
        settle();
        chk("rw_err_clr",   64'(err),           64'h0);
        chk("rw_req_valid", 64'(mem_req_valid), 64'h0);
        step();
        reset = 1'b1;
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0BAD;
        settle();
        chk("rw_no_rsp", 64'(io_rsp_valid), 64'h0);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("rw_err_set", 64'(err), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_block_ram_arbiter
`default_nettype wire
